// File: rtl/pong_pkg.sv
// Shared video geometry and packed-field helpers for the pong display path.
package pong_pkg;

    localparam int H_VIDEO = 640;
    localparam int V_VIDEO = 480;
    localparam int COORD_W = 10;
    localparam int SIZE_W  = 8;

    function automatic int unsigned coord_lsb(input int unsigned idx);
        return idx * COORD_W;
    endfunction

    function automatic int unsigned size_lsb(input int unsigned idx);
        return idx * SIZE_W;
    endfunction

    function automatic int unsigned rgb_lsb(input int unsigned idx, input int unsigned color_w);
        return idx * 3 * color_w;
    endfunction

endpackage

// File: rtl/sprite_hit.sv
// Bounding-box test for one rectangular sprite against the current pixel.
module sprite_hit
    import pong_pkg::*;
(
    input  logic               en,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic [SIZE_W-1:0]  size_w,
    input  logic [SIZE_W-1:0]  size_h,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    output logic               hit
);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    // One extra bit on the far edge so a sprite near the right/bottom limit never wraps.
    always_comb begin
        x_end = {1'b0, pos_x} + {{(COORD_W - SIZE_W + 1){1'b0}}, size_w};
        y_end = {1'b0, pos_y} + {{(COORD_W - SIZE_W + 1){1'b0}}, size_h};
        hit   = en
             && (pixel_x >= pos_x) && ({1'b0, pixel_x} < x_end)
             && (pixel_y >= pos_y) && ({1'b0, pixel_y} < y_end);
    end

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite/net compositor with per-frame sprite overlap reporting.
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int COLOR_W     = 1,
    parameter int H_VIDEO     = pong_pkg::H_VIDEO,
    parameter int V_VIDEO     = pong_pkg::V_VIDEO,
    parameter int NET_SIZE    = 12,
    parameter int NET_PHASE   = 18
) (
    input  logic                                    clk_0,
    input  logic                                    rst,
    input  logic [pong_pkg::COORD_W-1:0]            pixel_x,
    input  logic [pong_pkg::COORD_W-1:0]            pixel_y,
    input  logic                                    video_on,
    input  logic [pong_pkg::COORD_W*NUM_SPRITES-1:0] spr_x,
    input  logic [pong_pkg::COORD_W*NUM_SPRITES-1:0] spr_y,
    input  logic [pong_pkg::SIZE_W*NUM_SPRITES-1:0]  spr_w,
    input  logic [pong_pkg::SIZE_W*NUM_SPRITES-1:0]  spr_h,
    input  logic [NUM_SPRITES-1:0]                  spr_en,
    input  logic [3*COLOR_W*NUM_SPRITES-1:0]        spr_rgb,
    input  logic                                    net_en,
    output logic [COLOR_W-1:0]                      red,
    output logic [COLOR_W-1:0]                      green,
    output logic [COLOR_W-1:0]                      blue,
    output logic [NUM_SPRITES-1:0]                  hit_flags,
    output logic                                    frame_done
);

    localparam int CW     = pong_pkg::COORD_W;
    localparam int DASH_W = $clog2(2 * NET_SIZE);

    localparam logic [DASH_W-1:0] DASH_LOAD  = DASH_W'(NET_PHASE);
    localparam logic [DASH_W-1:0] DASH_LAST  = DASH_W'(2 * NET_SIZE - 1);
    localparam logic [DASH_W-1:0] DASH_ON    = DASH_W'(NET_SIZE);
    localparam logic [CW-1:0]     NET_LO     = CW'(H_VIDEO / 2 - NET_SIZE / 2);
    localparam logic [CW-1:0]     NET_HI     = CW'(H_VIDEO / 2 + NET_SIZE / 2 - 1);
    localparam logic [CW-1:0]     X_LAST     = CW'(H_VIDEO - 1);
    localparam logic [CW-1:0]     Y_LAST     = CW'(V_VIDEO - 1);

    logic [NUM_SPRITES-1:0]   hit_vec;
    logic [DASH_W-1:0]        dash_cnt;
    logic [DASH_W-1:0]        dash_next;
    logic                     net_hit;

    logic [NUM_SPRITES-1:0]   s1_hit;
    logic                     s1_net;
    logic                     s1_video;
    logic                     s1_last;

    logic [NUM_SPRITES-1:0]   acc;
    logic                     multi;
    logic [NUM_SPRITES-1:0]   contrib;
    logic [3*COLOR_W-1:0]     pix;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
        sprite_hit u_hit (
            .en      (spr_en[i]),
            .pos_x   (spr_x[pong_pkg::coord_lsb(i) +: pong_pkg::COORD_W]),
            .pos_y   (spr_y[pong_pkg::coord_lsb(i) +: pong_pkg::COORD_W]),
            .size_w  (spr_w[pong_pkg::size_lsb(i) +: pong_pkg::SIZE_W]),
            .size_h  (spr_h[pong_pkg::size_lsb(i) +: pong_pkg::SIZE_W]),
            .pixel_x (pixel_x),
            .pixel_y (pixel_y),
            .hit     (hit_vec[i])
        );
    end

    // Net coverage uses the counter value after this pixel's update, not the stored one.
    always_comb begin
        dash_next = dash_cnt;
        if (video_on && pixel_x == '0) begin
            if (pixel_y == '0)
                dash_next = DASH_LOAD;
            else if (dash_cnt == DASH_LAST)
                dash_next = '0;
            else
                dash_next = dash_cnt + DASH_W'(1);
        end
        net_hit = net_en && (dash_next < DASH_ON)
               && (pixel_x >= NET_LO) && (pixel_x <= NET_HI);
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            dash_cnt <= '0;
            s1_hit   <= '0;
            s1_net   <= 1'b0;
            s1_video <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            dash_cnt <= dash_next;
            s1_hit   <= hit_vec;
            s1_net   <= net_hit;
            s1_video <= video_on;
            s1_last  <= video_on && (pixel_x == X_LAST) && (pixel_y == Y_LAST);
        end
    end

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    always_comb begin
        multi   = (s1_hit & (s1_hit - NUM_SPRITES'(1))) != '0;
        contrib = (s1_video && multi) ? s1_hit : '0;
    end

    // Walk from the highest index down so the lowest covering sprite is the final assignment.
    always_comb begin
        pix = s1_net ? '1 : '0;
        for (int unsigned i = NUM_SPRITES; i > 0; i--) begin
            if (s1_hit[i-1])
                pix = spr_rgb[pong_pkg::rgb_lsb(i - 1, COLOR_W) +: 3*COLOR_W];
        end
        if (!s1_video)
            pix = '0;
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            hit_flags  <= '0;
            frame_done <= 1'b0;
            acc        <= '0;
        end else begin
            {red, green, blue} <= pix;
            frame_done         <= s1_last;
            if (s1_last) begin
                hit_flags <= acc | contrib;
                acc       <= '0;
            end else begin
                acc <= acc | contrib;
            end
        end
    end

endmodule
